// File: rtl/difftest_step_batcher_if.sv
// Handshake bundle between the difftest step source, the batcher and the checker side.
// The batcher uses the slave modport; the driver/checker uses the master modport.
interface difftest_step_batcher_if #(
    parameter int STEP_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
);
    logic [STEP_WIDTH-1:0] step_in;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_step;
    logic                  overflow;

    modport master (
        output step_in,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_step,
        input  overflow
    );

    modport slave (
        input  step_in,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_step,
        output overflow
    );
endinterface

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle difftest commit step counts; releases on threshold, idle timeout or flush.
// Optional statistics counters are compiled in with `define BATCHER_STATS_EN.
module difftest_step_batcher #(
    parameter int STEP_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int THRESHOLD  = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    difftest_step_batcher_if.slave  bus
`ifdef BATCHER_STATS_EN
    ,
    output logic [31:0]             stat_batches,
    output logic [63:0]             stat_steps,
    output logic [15:0]             stat_max_hold
`endif
);

    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;
    localparam logic [ACC_WIDTH-1:0] THRESH    = ACC_WIDTH'(THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    // Returns {saturated, value}; value is clamped to ACC_MAX when the carry is set.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [STEP_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] wide;
        wide = {1'b0, a} + {{(ACC_WIDTH + 1 - STEP_WIDTH){1'b0}}, b};
        return wide[ACC_WIDTH] ? {1'b1, ACC_MAX} : wide;
    endfunction

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [ACC_WIDTH-1:0]   spill_reg, spill_next;
    logic [CNT_WIDTH-1:0]   idle_cnt_reg, idle_cnt_next;
    logic                   out_valid_reg, out_valid_next;
    logic [ACC_WIDTH-1:0]   out_step_reg, out_step_next;
    logic                   overflow_reg, overflow_next;

    logic [ACC_WIDTH-1:0]   step_ext;
    logic [ACC_WIDTH:0]     acc_sum;
    logic [ACC_WIDTH:0]     spill_sum;
    logic                   step_nz;

    assign step_ext  = {{(ACC_WIDTH - STEP_WIDTH){1'b0}}, bus.step_in};
    assign step_nz   = (bus.step_in != '0);
    assign acc_sum   = sat_add(acc_reg, bus.step_in);
    assign spill_sum = sat_add(spill_reg, bus.step_in);

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        spill_next    = spill_reg;
        idle_cnt_next = idle_cnt_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            S_IDLE: begin
                // flush has no effect here: an empty batch is never emitted.
                acc_next      = step_ext;
                idle_cnt_next = '0;
                if (step_ext >= THRESH) begin
                    state_next = S_HOLD;
                end else if (step_nz) begin
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_next      = acc_sum[ACC_WIDTH-1:0];
                idle_cnt_next = step_nz ? '0 : idle_cnt_reg + CNT_WIDTH'(1);
                if ((acc_sum[ACC_WIDTH-1:0] >= THRESH) || bus.flush ||
                    (!step_nz && (idle_cnt_reg == IDLE_LAST))) begin
                    state_next    = S_HOLD;
                    idle_cnt_next = '0;
                end
            end
            S_HOLD: begin
                // Steps arriving while the batch waits go to spill; on the accepting
                // cycle that cycle's step is folded into the next batch exactly once.
                if (spill_sum[ACC_WIDTH]) begin
                    overflow_next = 1'b1;
                end
                if (bus.out_ready) begin
                    acc_next   = spill_sum[ACC_WIDTH-1:0];
                    spill_next = '0;
                    if (spill_sum[ACC_WIDTH-1:0] >= THRESH) begin
                        state_next = S_HOLD;
                    end else if (spill_sum[ACC_WIDTH-1:0] != '0) begin
                        state_next = S_ACCUM;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    spill_next = spill_sum[ACC_WIDTH-1:0];
                end
            end
            default: begin
                state_next = S_IDLE;
                acc_next   = '0;
            end
        endcase

        out_valid_next = (state_next == S_HOLD);
        out_step_next  = (state_next == S_HOLD) ? acc_next : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            spill_reg     <= '0;
            idle_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_step_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            spill_reg     <= spill_next;
            idle_cnt_reg  <= idle_cnt_next;
            out_valid_reg <= out_valid_next;
            out_step_reg  <= out_step_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_step  = out_step_reg;
    assign bus.overflow  = overflow_reg;

`ifdef BATCHER_STATS_EN
    logic [31:0] stat_batches_reg;
    logic [63:0] stat_steps_reg;
    logic [15:0] stat_max_hold_reg;
    logic [15:0] hold_run_reg;
    logic [15:0] hold_run_next;
    logic        fire;
    logic        stall;

    assign fire          = out_valid_reg && bus.out_ready;
    assign stall         = out_valid_reg && !bus.out_ready;
    assign hold_run_next = (hold_run_reg == 16'hFFFF) ? 16'hFFFF : hold_run_reg + 16'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_batches_reg  <= '0;
            stat_steps_reg    <= '0;
            stat_max_hold_reg <= '0;
            hold_run_reg      <= '0;
        end else begin
            if (fire) begin
                stat_batches_reg <= stat_batches_reg + 32'd1;
                stat_steps_reg   <= stat_steps_reg + {{(64 - ACC_WIDTH){1'b0}}, out_step_reg};
            end
            if (stall) begin
                hold_run_reg <= hold_run_next;
                if (hold_run_next > stat_max_hold_reg) begin
                    stat_max_hold_reg <= hold_run_next;
                end
            end else begin
                hold_run_reg <= '0;
            end
        end
    end

    assign stat_batches  = stat_batches_reg;
    assign stat_steps    = stat_steps_reg;
    assign stat_max_hold = stat_max_hold_reg;
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Bench for difftest_step_batcher: directed vector table, multi-cycle corner sequences,
// then randomized traffic compared against a batch-level reference model.
module tb_difftest_step_batcher;

    localparam int SW   = 8;
    localparam int AW   = 16;
    localparam int TH   = 16;
    localparam int TO   = 8;
    localparam int MAXV = 65535;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    difftest_step_batcher_if #(.STEP_WIDTH(SW), .ACC_WIDTH(AW)) dif ();

`ifdef BATCHER_STATS_EN
    logic [31:0] stat_batches;
    logic [63:0] stat_steps;
    logic [15:0] stat_max_hold;
`endif

    difftest_step_batcher #(
        .STEP_WIDTH(SW), .ACC_WIDTH(AW), .THRESHOLD(TH), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(dif)
`ifdef BATCHER_STATS_EN
        ,
        .stat_batches(stat_batches),
        .stat_steps(stat_steps),
        .stat_max_hold(stat_max_hold)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an open batch being collected, an optional released batch
    // waiting for the checker, and steps parked while that batch waits.
    int     m_open, m_zero_run, m_held, m_spill;
    bit     m_has_batch, m_ovf;
    longint total_in, accepted_sum;

    typedef struct {
        int step;
        bit fl;
        bit rdy;
        bit ev;
        int es;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int step, input bit fl, input bit rdy, input bit rst_n);
        int s;
        if (!rst_n) begin
            m_open = 0; m_zero_run = 0; m_held = 0; m_spill = 0;
            m_has_batch = 0; m_ovf = 0;
        end else if (m_has_batch) begin
            s = m_spill + step;
            if (s > MAXV) begin
                s = MAXV;
                m_ovf = 1;
            end
            if (rdy) begin
                m_spill = 0;
                m_has_batch = 0;
                m_zero_run = 0;
                if (s >= TH) begin
                    m_has_batch = 1;
                    m_held = s;
                end else begin
                    m_open = s;
                end
            end else begin
                m_spill = s;
            end
        end else if (m_open == 0) begin
            m_zero_run = 0;
            if (step >= TH) begin
                m_has_batch = 1;
                m_held = step;
            end else begin
                m_open = step;
            end
        end else begin
            m_open = (m_open + step > MAXV) ? MAXV : m_open + step;
            m_zero_run = (step == 0) ? m_zero_run + 1 : 0;
            if (m_open >= TH || fl || m_zero_run == TO) begin
                m_has_batch = 1;
                m_held = m_open;
                m_open = 0;
                m_zero_run = 0;
            end
        end
    endtask

    // Drives one cycle of inputs (at the falling edge), advances one clock, returns at
    // the next falling edge where outputs are sampled.
    task automatic apply(input int step, input bit fl, input bit rdy, input bit rst_n);
        dif.step_in   = SW'(step);
        dif.flush     = fl;
        dif.out_ready = rdy;
        reset         = rst_n;
        if (!rst_n) begin
            total_in = 0;
            accepted_sum = 0;
        end else begin
            total_in += step;
            if (dif.out_valid && rdy) begin
                accepted_sum += longint'(dif.out_step);
                $display("batch accepted: out_step=%0d", dif.out_step);
            end
        end
        model_step(step, fl, rdy, rst_n);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_valid"}, longint'(dif.out_valid), longint'(m_has_batch));
        if (m_has_batch) chk({tag, " out_step"}, longint'(dif.out_step), longint'(m_held));
        chk({tag, " overflow"}, longint'(dif.overflow), longint'(m_ovf));
    endtask

    initial begin
        dif.step_in = '0;
        dif.flush = 1'b0;
        dif.out_ready = 1'b0;
        total_in = 0;
        accepted_sum = 0;
        @(negedge clock);
        apply(0, 0, 0, 0);
        apply(0, 0, 0, 0);
        chk("reset out_valid", longint'(dif.out_valid), 0);
        chk("reset out_step", longint'(dif.out_step), 0);
        chk("reset overflow", longint'(dif.overflow), 0);

        // Threshold batch, idle-timeout batch, flush from IDLE/ACCUM, flush on crossing.
        for (int i = 0; i < 4; i++) tbl.push_back('{4, 1'b0, 1'b1, (i == 3), 16});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{3, 1'b0, 1'b1, 1'b0, 0});
        for (int i = 0; i < 8; i++) tbl.push_back('{0, 1'b0, 1'b1, (i == 7), 3});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b0, 0});
        tbl.push_back('{5, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{0, 1'b1, 1'b1, 1'b1, 5});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{10, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{8, 1'b1, 1'b1, 1'b1, 18});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{0, 1'b0, 1'b1, 1'b0, 0});
        foreach (tbl[i]) begin
            apply(tbl[i].step, tbl[i].fl, tbl[i].rdy, 1'b1);
            chk($sformatf("vec%0d out_valid", i), longint'(dif.out_valid), longint'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d out_step", i), longint'(dif.out_step), longint'(tbl[i].es));
            chk($sformatf("vec%0d overflow", i), longint'(dif.overflow), 0);
        end
`ifdef BATCHER_STATS_EN
        chk("stat_batches", longint'(stat_batches), 4);
        chk("stat_steps", longint'(stat_steps), 42);
`endif

        // Held batch with back-pressure; handshake step folds into the next batch.
        apply(16, 0, 0, 1);
        chk("hold enter valid", longint'(dif.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            apply(2, 0, 0, 1);
            chk($sformatf("hold stall%0d out_step", i), longint'(dif.out_step), 16);
            chk($sformatf("hold stall%0d valid", i), longint'(dif.out_valid), 1);
        end
        apply(1, 0, 1, 1);
        chk("handshake to accum valid", longint'(dif.out_valid), 0);
        apply(5, 0, 0, 1);
        chk("acc 11 + 5 valid", longint'(dif.out_valid), 1);
        chk("acc 11 + 5 out_step", longint'(dif.out_step), 16);
        apply(0, 0, 1, 1);
        chk("drain valid", longint'(dif.out_valid), 0);

        // Spill saturation: 257*255 is exactly 65535, the 258th add saturates.
        apply(20, 0, 0, 1);
        for (int k = 1; k <= 300; k++) begin
            apply(255, 0, 0, 1);
            chk($sformatf("spill k=%0d out_step", k), longint'(dif.out_step), 20);
            chk($sformatf("spill k=%0d overflow", k), longint'(dif.overflow), (k >= 258) ? 1 : 0);
        end
        apply(0, 0, 1, 1);
        chk("spill batch valid", longint'(dif.out_valid), 1);
        chk("spill batch out_step", longint'(dif.out_step), MAXV);
        chk("spill batch overflow", longint'(dif.overflow), 1);

        // Reset while holding a batch discards it.
        apply(0, 0, 0, 0);
        apply(20, 0, 0, 1);
        chk("pre-reset hold out_step", longint'(dif.out_step), 20);
        apply(0, 0, 0, 0);
        chk("mid-hold reset valid", longint'(dif.out_valid), 0);
        chk("mid-hold reset out_step", longint'(dif.out_step), 0);
        chk("mid-hold reset overflow", longint'(dif.overflow), 0);
        apply(0, 0, 1, 1);
        chk("after reset idle valid", longint'(dif.out_valid), 0);

        for (int n = 0; n < 4000; n++) begin
            int r;
            int step;
            bit fl, rdy, rst_n;
            r = int'($urandom_range(0, 99));
            if (r < 45) step = 0;
            else if (r < 85) step = int'($urandom_range(1, 8));
            else if (r < 95) step = int'($urandom_range(9, 20));
            else step = int'($urandom_range(0, 255));
            fl    = ($urandom_range(0, 99) < 5);
            rdy   = ($urandom_range(0, 99) < 55);
            rst_n = ($urandom_range(0, 999) >= 4);
            apply(step, fl, rdy, rst_n);
            check_model($sformatf("rand%0d", n));
        end

        if (!m_ovf) begin
            chk("step conservation",
                accepted_sum + m_open + m_spill + (m_has_batch ? m_held : 0), total_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
